// File: rtl/regnew_if.sv
// Bus bundle for the regnew registered selector: source select, two data
// sources and the registered output word.
interface regnew_if #(
  parameter int width = 8
);
  logic             en;
  logic [width-1:0] in1;
  logic [width-1:0] in2;
  logic [width-1:0] out;

  // master drives the sources and observes the result; slave is the register
  modport master (
    output en,
    output in1,
    output in2,
    input  out
  );

  modport slave (
    input  en,
    input  in1,
    input  in2,
    output out
  );
endinterface

// File: rtl/regnew.sv
// Single-stage registered 2:1 selector: loads in1 (en=1) or in2 (en=0) on
// every rising edge; synchronous active-high reset clears the register.
module regnew #(
  parameter int width = 8
) (
  input  logic      clk,
  input  logic      rst,
  regnew_if.slave   bus
);

  logic [width-1:0] q;

  // Loads every edge: en only steers the source, it never holds the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bus.en) begin
      q <= bus.in1;
    end else begin
      q <= bus.in2;
    end
  end

  assign bus.out = q;

endmodule

// File: tb/tb_regnew.sv
// Bench for regnew: an 8-bit and a 16-bit instance share clk/rst; checks a
// vector table, hand-written edge-timing sequences and random traffic.
module tb_regnew;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regnew_if #(.width(8))  a_if ();
  regnew_if #(.width(16)) b_if ();

  regnew #(.width(8))  dut8  (.clk(clk), .rst(rst), .bus(a_if));
  regnew #(.width(16)) dut16 (.clk(clk), .rst(rst), .bus(b_if));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [7:0]  exp8;
    logic [15:0] exp16;
  } vec_t;

  vec_t vecs[$];
  logic [7:0]  exp_q8[$];
  logic [15:0] exp_q16[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive on the falling edge, return just after the next rising edge
  task automatic apply(input logic r, input logic e, input logic [15:0] x1, input logic [15:0] x2);
    @(negedge clk);
    rst      = r;
    a_if.en  = e;
    a_if.in1 = x1[7:0];
    a_if.in2 = x2[7:0];
    b_if.en  = e;
    b_if.in1 = x1;
    b_if.in2 = x2;
    @(posedge clk);
    #1;
  endtask

  // behavioural reference: what the register must hold after the edge
  function automatic logic [15:0] model(input logic r, input logic e,
                                        input logic [15:0] x1, input logic [15:0] x2);
    if (r) return 16'h0000;
    return e ? x1 : x2;
  endfunction

  initial begin
    logic [15:0] m;
    logic        r, e;
    logic [15:0] x1, x2;
    logic [7:0]  e8;
    logic [15:0] e16;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a_if.en  = 1'b0; a_if.in1 = '0; a_if.in2 = '0;
    b_if.en  = 1'b0; b_if.in1 = '0; b_if.in2 = '0;

    // rst, en, in1, in2, expected 8-bit out, expected 16-bit out
    vecs.push_back('{1'b1, 1'b1, 16'h009D, 16'h00BC, 8'h00, 16'h0000});
    vecs.push_back('{1'b1, 1'b1, 16'h009D, 16'h00BC, 8'h00, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 16'h0012, 16'h0034, 8'h00, 16'h0000});
    vecs.push_back('{1'b0, 1'b1, 16'h009D, 16'h00BC, 8'h9D, 16'h009D});
    vecs.push_back('{1'b0, 1'b1, 16'h009F, 16'h00FD, 8'h9F, 16'h009F});
    vecs.push_back('{1'b0, 1'b0, 16'h008D, 16'h0031, 8'h31, 16'h0031});
    vecs.push_back('{1'b0, 1'b0, 16'h0081, 16'h00B1, 8'hB1, 16'h00B1});
    vecs.push_back('{1'b0, 1'b1, 16'h009D, 16'h00BC, 8'h9D, 16'h009D});
    vecs.push_back('{1'b0, 1'b0, 16'h008D, 16'h0031, 8'h31, 16'h0031});
    vecs.push_back('{1'b0, 1'b1, 16'h009F, 16'h00FD, 8'h9F, 16'h009F});
    vecs.push_back('{1'b0, 1'b0, 16'h0081, 16'h00B1, 8'hB1, 16'h00B1});
    vecs.push_back('{1'b0, 1'b1, 16'h00AD, 16'h0021, 8'hAD, 16'h00AD});
    vecs.push_back('{1'b1, 1'b1, 16'h00FF, 16'h0000, 8'h00, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h005A, 8'h5A, 16'h005A});
    vecs.push_back('{1'b0, 1'b1, 16'hA55A, 16'h0FF0, 8'h5A, 16'hA55A});
    vecs.push_back('{1'b0, 1'b0, 16'hA55A, 16'h0FF0, 8'hF0, 16'h0FF0});
    vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'hFF, 16'hFFFF});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0001, 16'h8001, 8'h01, 16'h8001});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].in1, vecs[i].in2);
      chk($sformatf("vec%0d_w8", i),  {8'h00, a_if.out}, {8'h00, vecs[i].exp8});
      chk($sformatf("vec%0d_w16", i), b_if.out, vecs[i].exp16);
    end

    // out must only move at rising edges, whatever the inputs do in between
    apply(1'b0, 1'b1, 16'h1233, 16'h4444);
    chk("stab_load_w8", {8'h00, a_if.out}, 16'h0033);
    for (int i = 0; i < 6; i++) begin
      #1;
      a_if.in1 = 8'($urandom); a_if.in2 = 8'($urandom); a_if.en = i[0];
      b_if.in1 = 16'($urandom); b_if.in2 = 16'($urandom); b_if.en = i[0];
      chk("stab_hold_w8",  {8'h00, a_if.out}, 16'h0033);
      chk("stab_hold_w16", b_if.out, 16'h1233);
    end
    #1;
    a_if.en = 1'b1; a_if.in1 = 8'h66;
    b_if.en = 1'b1; b_if.in1 = 16'h6606;
    @(posedge clk); #1;
    chk("stab_next_w8",  {8'h00, a_if.out}, 16'h0066);
    chk("stab_next_w16", b_if.out, 16'h6606);

    // a reset pulse that rises and falls between edges is ignored
    a_if.en = 1'b1; a_if.in1 = 8'h77;
    b_if.en = 1'b0; b_if.in2 = 16'h7007;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_glitch_w8",  {8'h00, a_if.out}, 16'h0077);
    chk("rst_glitch_w16", b_if.out, 16'h7007);

    // random traffic against the reference model via expected queues
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 15) == 0);
      e  = 1'($urandom_range(0, 1));
      x1 = 16'($urandom);
      x2 = 16'($urandom);
      m  = model(r, e, x1, x2);
      exp_q8.push_back(m[7:0]);
      exp_q16.push_back(m);
      apply(r, e, x1, x2);
      e8  = exp_q8.pop_front();
      e16 = exp_q16.pop_front();
      chk("rand_w8",  {8'h00, a_if.out}, {8'h00, e8});
      chk("rand_w16", b_if.out, e16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
